alu_mc: RTL and testbench

Parametrised multi-cycle ALU, successor to the 8-bit add/subtract ALU of the CPU datapath. It adds logic, shift and iterative multiply operations, a four-bit flags register and a start/busy/done handshake. It sits between the A/B registers and the bus driver. The sequencer issues one operation at a time and waits on `done` for multi-cycle operations.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_mc_mul.sv | 47 ++++
 rtl/alu_mc.sv | 178 +++++++++++++++++
 tb/tb_alu_mc.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } alu_state_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_W = 4;

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per step, WIDTH steps.
// o_last flags the final step; o_prod is the accumulator value that step produces.
module alu_mc_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_last,
  output logic [2*WIDTH-1:0] o_prod
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_last    = i_step && (r_cnt == CW'(WIDTH - 1));
  assign o_prod    = w_acc_nxt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_acc    <= '0;
      r_mplier <= i_b;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops done one cycle after accept; MUL done WIDTH+1 cycles after.
// Multiplier compiled in only with ALU_MC_MUL_EN; otherwise opcode 7 yields 0 and busy stays 0.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             fi,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             cf,
  output logic             zf,
  output logic             nf,
  output logic             vf
);

  alu_state_t        r_state;
  alu_state_t        w_state_nxt;
  logic [WIDTH-1:0]  r_out;
  logic [FLAG_W-1:0] r_flags;
  logic              r_done;

  alu_op_t           w_op;
  logic              w_idle;
  logic              w_run;
  logic              w_accept;
  logic              w_is_mul;
  logic              w_mul_last;
  logic              w_sub;
  logic [WIDTH-1:0]  w_bx;
  logic [WIDTH:0]    w_sum;
  logic [WIDTH-1:0]  w_res;
  logic              w_c;
  logic              w_v;
  logic [FLAG_W-1:0] w_alu_flags;

  assign w_op     = alu_op_t'(op);
  assign w_accept = start && w_idle;

  // Single-cycle datapath; SUB reuses the adder as a + ~b + 1.
  always_comb begin
    w_sub = (w_op == OP_SUB);
    w_bx  = w_sub ? ~b : b;
    w_sum = {1'b0, a} + {1'b0, w_bx} + (WIDTH+1)'(w_sub);
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_SHL: begin
        w_res = {a[WIDTH-2:0], 1'b0};
        w_c   = a[WIDTH-1];
      end
      OP_SHR: begin
        w_res = {1'b0, a[WIDTH-1:1]};
        w_c   = a[0];
      end
      default: w_res = '0;
    endcase
    w_alu_flags         = '0;
    w_alu_flags[FLAG_C] = w_c;
    w_alu_flags[FLAG_Z] = (w_res == '0);
    w_alu_flags[FLAG_N] = w_res[WIDTH-1];
    w_alu_flags[FLAG_V] = w_v;
  end

`ifdef ALU_MC_MUL_EN
  logic [2*WIDTH-1:0] w_prod;
  logic [FLAG_W-1:0]  w_mul_flags;
  logic               w_hi_nz;
  logic               r_fi;

  assign w_is_mul = (w_op == OP_MUL);

  alu_mc_mul #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .clr_n  (clr_n),
    .i_load (w_accept && w_is_mul),
    .i_step (w_run),
    .i_a    (a),
    .i_b    (b),
    .o_last (w_mul_last),
    .o_prod (w_prod)
  );

  always_comb begin
    w_hi_nz             = (w_prod[2*WIDTH-1:WIDTH] != '0);
    w_mul_flags         = '0;
    w_mul_flags[FLAG_C] = w_hi_nz;
    w_mul_flags[FLAG_Z] = (w_prod[WIDTH-1:0] == '0);
    w_mul_flags[FLAG_N] = w_prod[WIDTH-1];
    w_mul_flags[FLAG_V] = w_hi_nz;
  end

  // fi is only valid in the accept cycle, so hold it for the completion edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_fi <= 1'b0;
    end else if (w_accept) begin
      r_fi <= fi;
    end
  end
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_last = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept && w_is_mul) w_state_nxt = ST_MUL_RUN;
      ST_MUL_RUN: if (w_mul_last)           w_state_nxt = ST_IDLE;
      default:                              w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_idle = (r_state == ST_IDLE);
`ifdef ALU_MC_MUL_EN
    w_run  = (r_state == ST_MUL_RUN);
`else
    w_run  = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_out   <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept && !w_is_mul) begin
        r_out  <= w_res;
        r_done <= 1'b1;
        if (fi && (w_op != OP_MUL)) r_flags <= w_alu_flags;
      end
`ifdef ALU_MC_MUL_EN
      if (w_mul_last) begin
        r_out  <= w_prod[WIDTH-1:0];
        r_done <= 1'b1;
        if (r_fi) r_flags <= w_mul_flags;
      end
`endif
    end
  end

  assign out  = r_out;
  assign busy = w_run;
  assign done = r_done;
  assign cf   = r_flags[FLAG_C];
  assign zf   = r_flags[FLAG_Z];
  assign nf   = r_flags[FLAG_N];
  assign vf   = r_flags[FLAG_V];

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: 8-bit instance checked every cycle against a behavioural model,
// plus a 16-bit instance checked with directed literal expectations.
module tb_alu_mc;
  import alu_pkg::*;

`ifdef ALU_MC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  logic        start8, fi8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, out8;
  logic        busy8, done8, cf8, zf8, nf8, vf8;

  logic        start16, fi16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, out16;
  logic        busy16, done16, cf16, zf16, nf16, vf16;

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .clr_n(clr_n), .start(start8), .op(op8), .a(a8), .b(b8), .fi(fi8),
    .out(out8), .busy(busy8), .done(done8), .cf(cf8), .zf(zf8), .nf(nf8), .vf(vf8)
  );

  alu_mc #(.WIDTH(16)) dut16 (
    .clk(clk), .clr_n(clr_n), .start(start16), .op(op16), .a(a16), .b(b16), .fi(fi16),
    .out(out16), .busy(busy16), .done(done16), .cf(cf16), .zf(zf16), .nf(nf16), .vf(vf16)
  );

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;
  int nb16 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour of one 8-bit single-cycle op, in plain integer arithmetic.
  typedef struct packed { logic [7:0] res; logic c, z, n, v; } exp_t;

  function automatic exp_t ref8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ua = int'(a);
    int ub = int'(b);
    int sa = (ua > 127) ? ua - 256 : ua;
    int sb = (ub > 127) ? ub - 256 : ub;
    int r = 0;
    int s = 0;
    e.c = 1'b0;
    e.v = 1'b0;
    case (op)
      3'd0: begin r = ua + ub; s = sa + sb; e.c = (r > 255); e.v = (s > 127) || (s < -128); end
      3'd1: begin r = ua - ub; s = sa - sb; e.c = (ua >= ub); e.v = (s > 127) || (s < -128); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: begin r = ua * 2; e.c = (ua > 127); end
      3'd6: begin r = ua / 2; e.c = (ua % 2 == 1); end
      default: r = 0;
    endcase
    e.res = r[7:0];
    e.z   = (e.res == 8'd0);
    e.n   = e.res[7];
    return e;
  endfunction

  exp_t m_e;
  always_comb m_e = ref8(op8, a8, b8);

  logic [7:0] m_out;
  logic       m_c, m_z, m_n, m_v, m_done, m_fi;
  int         m_left, m_prod;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_out <= 8'd0; m_c <= 1'b0; m_z <= 1'b0; m_n <= 1'b0; m_v <= 1'b0;
      m_done <= 1'b0; m_left <= 0; m_prod <= 0; m_fi <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_out  <= m_prod[7:0];
          m_done <= 1'b1;
          if (m_fi) begin
            m_c <= (m_prod > 255); m_v <= (m_prod > 255);
            m_z <= (m_prod[7:0] == 8'd0); m_n <= m_prod[7];
          end
        end
      end else if (start8) begin
        if (op8 == 3'd7 && MUL_EN) begin
          m_left <= 8;
          m_prod <= int'(a8) * int'(b8);
          m_fi   <= fi8;
        end else begin
          m_out  <= m_e.res;
          m_done <= 1'b1;
          if (fi8 && op8 != 3'd7) begin
            m_c <= m_e.c; m_z <= m_e.z; m_n <= m_e.n; m_v <= m_e.v;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_out",  {24'd0, out8}, {24'd0, m_out});
      chk("cmp_busy", {31'd0, busy8}, {31'd0, (m_left > 0)});
      chk("cmp_done", {31'd0, done8}, {31'd0, m_done});
      chk("cmp_flags", {28'd0, cf8, zf8, nf8, vf8}, {28'd0, m_c, m_z, m_n, m_v});
    end
    if (busy16 === 1'b1) nb16++;
  end

  task automatic sync();
    @(posedge clk); #2;
  endtask

  task automatic go8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input logic f);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y; fi8 = f;
    sync();
    start8 = 1'b0;
  endtask

  task automatic go16(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y, input logic f);
    start16 = 1'b1; op16 = o; a16 = x; b16 = y; fi16 = f;
    sync();
    start16 = 1'b0;
  endtask

  task automatic flags8(input string nm, input logic c, input logic z, input logic n, input logic v);
    chk(nm, {28'd0, cf8, zf8, nf8, vf8}, {28'd0, c, z, n, v});
  endtask

  initial begin
    int lat, nb, ndone;
    bit got;
    clr_n = 1'b1;
    start8 = 1'b0; op8 = 3'd0; a8 = 8'd0; b8 = 8'd0; fi8 = 1'b0;
    start16 = 1'b0; op16 = 3'd0; a16 = 16'd0; b16 = 16'd0; fi16 = 1'b0;
    #3 clr_n = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_out", {24'd0, out8}, 32'd0);
    chk("rst_ctl", {30'd0, busy8, done8}, 32'd0);
    flags8("rst_flags", 1'b0, 1'b0, 1'b0, 1'b0);
    sync();
    clr_n = 1'b1;
    sync();

    go8(OP_ADD, 8'hFF, 8'h01, 1'b1);
    @(negedge clk);
    chk("add_ff_done", {31'd0, done8}, 32'd1);
    chk("add_ff_out", {24'd0, out8}, 32'h00);
    flags8("add_ff_flags", 1'b1, 1'b1, 1'b0, 1'b0);
    sync();

    go8(OP_SUB, 8'h05, 8'h07, 1'b1);
    @(negedge clk);
    chk("sub_out", {24'd0, out8}, 32'hFE);
    flags8("sub_flags", 1'b0, 1'b0, 1'b1, 1'b0);
    sync();
    go8(OP_ADD, 8'h7F, 8'h01, 1'b1);
    @(negedge clk);
    chk("add_ovf_out", {24'd0, out8}, 32'h80);
    flags8("add_ovf_flags", 1'b0, 1'b0, 1'b1, 1'b1);
    sync();

    go8(OP_ADD, 8'hFF, 8'h01, 1'b1);
    go8(OP_XOR, 8'h0F, 8'hF0, 1'b0);
    @(negedge clk);
    chk("xor_nofi_out", {24'd0, out8}, 32'hFF);
    flags8("xor_nofi_flags", 1'b1, 1'b1, 1'b0, 1'b0);
    sync();

    // back-to-back single-cycle ops with start held high
    start8 = 1'b1; fi8 = 1'b1;
    op8 = OP_ADD; a8 = 8'h01; b8 = 8'h02; sync();
    op8 = OP_SUB; a8 = 8'h09; b8 = 8'h03; sync();
    op8 = OP_SHR; a8 = 8'h81; b8 = 8'h00; sync();
    start8 = 1'b0;
    @(negedge clk);
    chk("b2b_done", {31'd0, done8}, 32'd1);
    chk("shr_out", {24'd0, out8}, 32'h40);
    flags8("shr_flags", 1'b1, 1'b0, 1'b0, 1'b0);
    sync();

    go8(OP_MUL, 8'h10, 8'h20, 1'b1);
    got = 1'b0; lat = 0; nb = 0;
    for (int i = 1; i <= 30 && !got; i++) begin
      @(negedge clk);
      if (busy8) nb++;
      if (done8) begin got = 1'b1; lat = i; end
      if (i == 2) begin start8 = 1'b1; op8 = OP_ADD; a8 = 8'h01; b8 = 8'h01; fi8 = 1'b1; end
      if (i == 4) start8 = 1'b0;
    end
    start8 = 1'b0;
    chk("mul_done_seen", {31'd0, got}, 32'd1);
    chk("mul_latency", lat, MUL_EN ? 32'd9 : 32'd1);
    chk("mul_busy_cycles", nb, MUL_EN ? 32'd8 : 32'd0);
    chk("mul_out", {24'd0, out8}, 32'h00);
    flags8("mul_flags", 1'b1, MUL_EN, 1'b0, MUL_EN);
    sync();
    @(negedge clk);
    chk("mul_ignored_start", {31'd0, done8}, 32'd0);
    sync();

    go8(OP_OR, 8'h3C, 8'h81, 1'b1);
    @(negedge clk);
    chk("or_out", {24'd0, out8}, 32'hBD);
    sync();
    go8(OP_MUL, 8'h0F, 8'h0F, 1'b1);
    sync(); sync(); sync();
    clr_n = 1'b0;
    #1;
    chk("abort_out", {24'd0, out8}, 32'd0);
    chk("abort_ctl", {30'd0, busy8, done8}, 32'd0);
    flags8("abort_flags", 1'b0, 1'b0, 1'b0, 1'b0);
    sync();
    clr_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("abort_no_done", ndone, 32'd0);
    sync();
    go8(OP_ADD, 8'h02, 8'h03, 1'b1);
    @(negedge clk);
    chk("post_abort_add", {24'd0, out8}, 32'h05);
    chk("post_abort_done", {31'd0, done8}, 32'd1);
    sync();

    go16(OP_SHL, 16'h8001, 16'h0000, 1'b1);
    @(negedge clk);
    chk("w16_shl_out", {16'd0, out16}, 32'h0002);
    chk("w16_shl_flags", {28'd0, cf16, zf16, nf16, vf16}, 32'b1000);
    chk("w16_shl_done", {31'd0, done16}, 32'd1);
    sync();
    go16(OP_MUL, 16'h1234, 16'h0002, 1'b1);
    got = 1'b0; lat = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (done16) begin got = 1'b1; lat = i; end
    end
    chk("w16_op7_done_seen", {31'd0, got}, 32'd1);
    chk("w16_op7_latency", lat, MUL_EN ? 32'd17 : 32'd1);
    chk("w16_op7_out", {16'd0, out16}, MUL_EN ? 32'h2468 : 32'h0000);
    chk("w16_op7_flags", {28'd0, cf16, zf16, nf16, vf16}, MUL_EN ? 32'b0000 : 32'b1000);
    sync();
    chk("w16_busy_cycles", nb16, MUL_EN ? 32'd16 : 32'd0);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
